// File: rtl/alu_serial_if.sv
// Handshake and data bundle for alu_serial: request side (a, b, opcode) and result side.
// The zero/overflow flag signals exist only when ALU_FLAGS_EN is defined.
interface alu_serial_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       opcode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             cout;
`ifdef ALU_FLAGS_EN
   logic             zero;
   logic             overflow;
`endif

   modport master (
`ifdef ALU_FLAGS_EN
      input  zero,
      input  overflow,
`endif
      output in_valid,
      input  in_ready,
      output a,
      output b,
      output opcode,
      input  out_valid,
      output out_ready,
      input  result,
      input  cout
   );

   modport slave (
`ifdef ALU_FLAGS_EN
      output zero,
      output overflow,
`endif
      input  in_valid,
      output in_ready,
      input  a,
      input  b,
      input  opcode,
      output out_valid,
      input  out_ready,
      output result,
      output cout
   );
endinterface

// File: rtl/alu_serial.sv
// Digit-serial WIDTH-bit ALU, DIGIT bits per clock, LSB digit first, opcode {ainv, binv, op[1:0]}.
// Optional zero/overflow flag outputs are built when ALU_FLAGS_EN is defined.
module alu_serial #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4
) (
   input logic         clk,
   input logic         rst_n,
   alu_serial_if.slave io
);
   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t            state_r;
   state_t            state_nx_s;
   logic              accept_s;
   logic              step_s;
   logic              last_s;

   logic [WIDTH-1:0]  a_r;
   logic [WIDTH-1:0]  b_r;
   logic [WIDTH-1:0]  acc_r;
   logic [3:0]        op_r;
   logic              carry_r;
   logic [CW-1:0]     cnt_r;

   logic [WIDTH-1:0]  result_r;
   logic              cout_r;
   logic              in_ready_r;
   logic              out_valid_r;
`ifdef ALU_FLAGS_EN
   logic              zero_r;
   logic              ovf_r;
`endif

   logic [DIGIT-1:0]  ap_s;
   logic [DIGIT-1:0]  bp_s;
   logic [DIGIT:0]    sum_ext_s;
   logic              cin_msb_s;
   logic              ovf_s;
   logic              less_s;
   logic [DIGIT-1:0]  digit_s;
   logic [WIDTH-1:0]  digit_ext_s;
   logic [WIDTH-1:0]  shifted_s;
   logic [WIDTH-1:0]  final_s;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state and sequencing strobes
   always_comb begin
      state_nx_s = state_r;
      accept_s   = 1'b0;
      step_s     = 1'b0;
      last_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (io.in_valid) begin
               accept_s   = 1'b1;
               state_nx_s = RUN;
            end else begin
               state_nx_s = IDLE;
            end
         end
         RUN: begin
            step_s = 1'b1;
            if (cnt_r == LAST_DIGIT) begin
               last_s     = 1'b1;
               state_nx_s = DONE;
            end else begin
               state_nx_s = RUN;
            end
         end
         DONE: begin
            if (io.out_ready) begin
               state_nx_s = IDLE;
            end else begin
               state_nx_s = DONE;
            end
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // One digit of the slice bank; the adder always runs so carry and overflow exist for every opcode
   always_comb begin
      ap_s      = a_r[DIGIT-1:0] ^ {DIGIT{op_r[3]}};
      bp_s      = b_r[DIGIT-1:0] ^ {DIGIT{op_r[2]}};
      sum_ext_s = {1'b0, ap_s} + {1'b0, bp_s} + {{DIGIT{1'b0}}, carry_r};
      cin_msb_s = sum_ext_s[DIGIT-1] ^ ap_s[DIGIT-1] ^ bp_s[DIGIT-1];
      ovf_s     = cin_msb_s ^ sum_ext_s[DIGIT];
      less_s    = sum_ext_s[DIGIT-1] ^ ovf_s;
      case (op_r[1:0])
         2'b00:   digit_s = ap_s & bp_s;
         2'b01:   digit_s = ap_s | bp_s;
         2'b10:   digit_s = ap_s ^ bp_s;
         2'b11:   digit_s = sum_ext_s[DIGIT-1:0];
         default: digit_s = {DIGIT{1'b0}};
      endcase
      digit_ext_s               = {WIDTH{1'b0}};
      digit_ext_s[DIGIT-1:0]    = digit_s;
      shifted_s                 = (acc_r >> DIGIT) | (digit_ext_s << (WIDTH - DIGIT));
      // SLT only knows 'less' once the MSB digit is done, so it replaces the whole word at the end
      if ((op_r[1:0] == 2'b10) && op_r[2]) begin
         final_s    = {WIDTH{1'b0}};
         final_s[0] = less_s;
      end else begin
         final_s = shifted_s;
      end
   end

   // Operand shifters, carry chain register and digit counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_r     <= {WIDTH{1'b0}};
         b_r     <= {WIDTH{1'b0}};
         acc_r   <= {WIDTH{1'b0}};
         op_r    <= 4'b0000;
         carry_r <= 1'b0;
         cnt_r   <= {CW{1'b0}};
      end else if (accept_s) begin
         a_r     <= io.a;
         b_r     <= io.b;
         acc_r   <= {WIDTH{1'b0}};
         op_r    <= io.opcode;
         carry_r <= io.opcode[2];
         cnt_r   <= {CW{1'b0}};
      end else if (step_s) begin
         a_r     <= a_r >> DIGIT;
         b_r     <= b_r >> DIGIT;
         acc_r   <= shifted_s;
         carry_r <= sum_ext_s[DIGIT];
         if (!last_s) begin
            cnt_r <= cnt_r + CW'(1);
         end
      end
   end

   // Output registers: handshake levels follow the next state, results load on the final digit only
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         result_r    <= {WIDTH{1'b0}};
         cout_r      <= 1'b0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
`ifdef ALU_FLAGS_EN
         zero_r      <= 1'b0;
         ovf_r       <= 1'b0;
`endif
      end else begin
         in_ready_r  <= (state_nx_s == IDLE);
         out_valid_r <= (state_nx_s == DONE);
         if (last_s) begin
            result_r <= final_s;
            cout_r   <= sum_ext_s[DIGIT];
`ifdef ALU_FLAGS_EN
            zero_r   <= ~|final_s;
            ovf_r    <= ovf_s;
`endif
         end
      end
   end

   assign io.in_ready  = in_ready_r;
   assign io.out_valid = out_valid_r;
   assign io.result    = result_r;
   assign io.cout      = cout_r;
`ifdef ALU_FLAGS_EN
   assign io.zero      = zero_r;
   assign io.overflow  = ovf_r;
`endif

endmodule

// File: tb/tb_alu_serial.sv
// Bench for alu_serial (WIDTH=32, DIGIT=4): directed table, backpressure, mid-run reset, random ops.
// Flag outputs are checked only when ALU_FLAGS_EN is defined.
module tb_alu_serial;
   localparam int WIDTH = 32;
   localparam int DIGIT = 4;
   localparam int NDIG  = WIDTH / DIGIT;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_serial_if #(.WIDTH(WIDTH)) bus ();
   alu_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (.clk(clk), .rst_n(rst_n), .io(bus));

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      logic [31:0] r;
      logic        c;
      logic        z;
      logic        v;
   } vec_t;

   vec_t tbl [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: whole-word arithmetic straight from the opcode definition
   task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                        output logic [31:0] r, output logic c, output logic z, output logic v);
      logic [31:0] ap, bp;
      logic [32:0] s;
      ap = op[3] ? ~a : a;
      bp = op[2] ? ~b : b;
      s  = {1'b0, ap} + {1'b0, bp} + {32'd0, op[2]};
      v  = (ap[31] == bp[31]) && (s[31] != ap[31]);
      case (op[1:0])
         2'd0:    r = ap & bp;
         2'd1:    r = ap | bp;
         2'd2:    r = op[2] ? (($signed(ap) < $signed(b)) ? 32'd1 : 32'd0) : (ap ^ bp);
         default: r = s[31:0];
      endcase
      c = s[32];
      z = (r == 32'd0);
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      int guard;
      guard = 0;
      while (!bus.in_ready && guard < 40) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!bus.in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL in_ready_timeout: got 0, expected 1 within 40 cycles");
      end
      bus.a        = a;
      bus.b        = b;
      bus.opcode   = op;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                         output logic [31:0] r, output logic c, output logic z, output logic v,
                         output int lat);
      issue(a, b, op);
      wait_valid(lat);
      r = bus.result;
      c = bus.cout;
`ifdef ALU_FLAGS_EN
      z = bus.zero;
      v = bus.overflow;
`else
      z = 1'b0;
      v = 1'b0;
`endif
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check("idle_ready_after_handshake", {31'd0, bus.in_ready}, 32'd1);
   endtask

   task automatic check_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op);
      logic [31:0] r, er;
      logic c, z, v, ec, ez, ev;
      int lat;
      model(a, b, op, er, ec, ez, ev);
      run_op(a, b, op, r, c, z, v, lat);
      check({tag, "_latency"}, lat, NDIG);
      check({tag, "_result"}, r, er);
      check({tag, "_cout"}, {31'd0, c}, {31'd0, ec});
`ifdef ALU_FLAGS_EN
      check({tag, "_zero"}, {31'd0, z}, {31'd0, ez});
      check({tag, "_overflow"}, {31'd0, v}, {31'd0, ev});
`endif
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r, held;
      logic c, z, v;
      int lat;

      tbl[0] = '{32'h7FFFFFFF, 32'h00000001, 4'b0011, 32'h80000000, 1'b0, 1'b0, 1'b1};
      tbl[1] = '{32'h00000005, 32'h00000007, 4'b0111, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{32'h00000007, 32'h00000007, 4'b0111, 32'h00000000, 1'b1, 1'b1, 1'b0};
      tbl[3] = '{32'h80000000, 32'h00000001, 4'b0110, 32'h00000001, 1'b1, 1'b0, 1'b1};
      tbl[4] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 4'b0110, 32'h00000000, 1'b0, 1'b1, 1'b1};
      tbl[5] = '{32'hF0F0F0F0, 32'h0F0F0000, 4'b1100, 32'h00000F0F, 1'b1, 1'b0, 1'b0};
      tbl[6] = '{32'hF0F0F0F0, 32'h0F0F0000, 4'b0010, 32'hFFFFF0F0, 1'b0, 1'b0, 1'b0};
      tbl[7] = '{32'h12345678, 32'h0000FFFF, 4'b0001, 32'h1234FFFF, 1'b0, 1'b0, 1'b0};
      tbl[8] = '{32'h00000002, 32'h00000003, 4'b0011, 32'h00000005, 1'b0, 1'b0, 1'b0};

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a         = 32'd0;
      bus.b         = 32'd0;
      bus.opcode    = 4'd0;
      rst_n         = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_result", bus.result, 32'd0);
      check("rst_cout", {31'd0, bus.cout}, 32'd0);
`ifdef ALU_FLAGS_EN
      check("rst_zero", {31'd0, bus.zero}, 32'd0);
      check("rst_overflow", {31'd0, bus.overflow}, 32'd0);
`endif
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

      // Directed vectors with hand-derived expectations
      for (int i = 0; i < 9; i++) begin
         run_op(tbl[i].a, tbl[i].b, tbl[i].op, r, c, z, v, lat);
         check($sformatf("vec%0d_latency", i), lat, NDIG);
         check($sformatf("vec%0d_result", i), r, tbl[i].r);
         check($sformatf("vec%0d_cout", i), {31'd0, c}, {31'd0, tbl[i].c});
`ifdef ALU_FLAGS_EN
         check($sformatf("vec%0d_zero", i), {31'd0, z}, {31'd0, tbl[i].z});
         check($sformatf("vec%0d_overflow", i), {31'd0, v}, {31'd0, tbl[i].v});
`endif
      end

      // Backpressure in DONE with a competing request on the input
      issue(32'd100, 32'd23, 4'b0011);
      wait_valid(lat);
      check("bp_latency", lat, NDIG);
      held = bus.result;
      check("bp_result", held, 32'd123);
      bus.a        = 32'h11111111;
      bus.b        = 32'h22222222;
      bus.opcode   = 4'b0011;
      bus.in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check("bp_result_stable", bus.result, 32'd123);
         check("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
         check("bp_out_valid_held", {31'd0, bus.out_valid}, 32'd1);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check("bp_released_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("bp_released_in_ready", {31'd0, bus.in_ready}, 32'd1);
      check_op("bp_next", 32'h11111111, 32'h22222222, 4'b0011);

      // Reset in the middle of RUN abandons the operation
      issue(32'h0000ABCD, 32'h00000001, 4'b0011);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("midrst_result", bus.result, 32'd0);
      check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("midrst_cout", {31'd0, bus.cout}, 32'd0);
      check_op("post_rst_add", 32'd2, 32'd3, 4'b0011);

      // Random operands and opcodes against the reference
      for (int n = 0; n < 150; n++) begin
         logic [31:0] ra, rb;
         logic [3:0]  rop;
         ra  = $urandom;
         rb  = $urandom;
         rop = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 5))
            0: rb = ra;
            1: ra = 32'h80000000;
            2: rb = 32'hFFFFFFFF;
            default: ;
         endcase
         check_op($sformatf("rand%0d_op%0h", n, rop), ra, rb, rop);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
